// File: rtl/fetch_stage_if.sv
// Fetch-stage bundle: redirect input, IMEM request/response channel and decode-side output.
// master = fetch stage, slave = memory/decode/branch-unit side.
interface fetch_stage_if #(
   parameter int unsigned XLEN = 32
);
   logic            redirect_valid;
   logic [XLEN-1:0] redirect_pc;
   logic            imem_req_valid;
   logic            imem_req_ready;
   logic [XLEN-1:0] imem_req_addr;
   logic            imem_rsp_valid;
   logic [31:0]     imem_rsp_data;
   logic            instr_valid;
   logic            instr_ready;
   logic [31:0]     instr_data;
   logic [XLEN-1:0] instr_pc;
   logic [XLEN-1:0] instr_pc_plus4;
   logic            fetch_err;

   modport master (
      input  redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data,
             instr_ready,
      output imem_req_valid, imem_req_addr, instr_valid, instr_data, instr_pc,
             instr_pc_plus4, fetch_err
   );

   modport slave (
      output redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data,
             instr_ready,
      input  imem_req_valid, imem_req_addr, instr_valid, instr_data, instr_pc,
             instr_pc_plus4, fetch_err
   );
endinterface

// File: rtl/fetch_stage.sv
// RV32I fetch stage: credit-limited IMEM requests, in-order response FIFO, redirect flush.
// Optional misaligned-redirect trap enabled by defining FETCH_MISALIGN_CHECK_EN.
module fetch_stage #(
   parameter int unsigned    XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0,
   parameter int unsigned    DEPTH    = 4
) (
   input logic             clk,
   input logic             reset,
   fetch_stage_if.master   bus
);
   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned PW = $clog2(DEPTH);
   // Dropped responses are no longer charged to the request credit, so several
   // back-to-back flushes can stack them up; extra headroom covers that.
   localparam int unsigned DW = CW + 4;

   logic [XLEN-1:0] pc_q;
   logic [CW-1:0]   count_q;
   logic [CW-1:0]   outstanding_q;
   logic [DW-1:0]   drop_q;
   logic            err_q;
   logic [PW-1:0]   rd_ptr_q, wr_ptr_q;
   logic [PW-1:0]   tag_rd_q, tag_wr_q;
   logic [XLEN-1:0] fifo_pc   [DEPTH];
   logic [31:0]     fifo_data [DEPTH];
   logic [XLEN-1:0] tag_pc    [DEPTH];

   logic            credit, accept, rsp_take, rsp_drop, push, pop;
   logic [XLEN-1:0] target;

   always_comb begin
      credit   = ({1'b0, outstanding_q} + {1'b0, count_q}) < (CW + 1)'(DEPTH);
      bus.imem_req_valid = reset & !bus.redirect_valid & !err_q & credit;
      bus.imem_req_addr  = pc_q;
      accept   = bus.imem_req_valid & bus.imem_req_ready;
      rsp_take = bus.imem_rsp_valid & ((drop_q != '0) | (outstanding_q != '0));
      rsp_drop = rsp_take & (drop_q != '0);
      push     = rsp_take & !rsp_drop & !bus.redirect_valid;
      bus.instr_valid    = (count_q != '0) & !bus.redirect_valid;
      bus.instr_data     = fifo_data[rd_ptr_q];
      bus.instr_pc       = fifo_pc[rd_ptr_q];
      bus.instr_pc_plus4 = fifo_pc[rd_ptr_q] + XLEN'(4);
      pop      = bus.instr_valid & bus.instr_ready;
   end

`ifdef FETCH_MISALIGN_CHECK_EN
   assign target        = bus.redirect_pc;
   assign bus.fetch_err = err_q;
`else
   assign target        = bus.redirect_pc & ~XLEN'(3);
   assign bus.fetch_err = 1'b0;
   assign err_q         = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc_q          <= RESET_PC;
         count_q       <= '0;
         outstanding_q <= '0;
         drop_q        <= '0;
         rd_ptr_q      <= '0;
         wr_ptr_q      <= '0;
         tag_rd_q      <= '0;
         tag_wr_q      <= '0;
`ifdef FETCH_MISALIGN_CHECK_EN
         err_q         <= 1'b0;
`endif
         for (int unsigned i = 0; i < DEPTH; i++) begin
            fifo_pc[i]   <= RESET_PC;
            fifo_data[i] <= '0;
         end
      end else if (bus.redirect_valid) begin
         // Everything still in flight becomes a drop; the tag queue is realigned
         // so the next accepted request is also the next tagged response.
         pc_q          <= target;
         count_q       <= '0;
         rd_ptr_q      <= wr_ptr_q;
         outstanding_q <= '0;
         tag_rd_q      <= tag_wr_q;
         drop_q        <= drop_q + DW'(outstanding_q) - DW'(rsp_take);
`ifdef FETCH_MISALIGN_CHECK_EN
         err_q         <= |bus.redirect_pc[1:0];
`endif
      end else begin
         if (accept) begin
            pc_q     <= pc_q + XLEN'(4);
            tag_wr_q <= tag_wr_q + 1'b1;
         end
         outstanding_q <= outstanding_q + CW'(accept) - CW'(rsp_take & !rsp_drop);
         if (rsp_drop) drop_q <= drop_q - 1'b1;
         if (rsp_take & !rsp_drop) tag_rd_q <= tag_rd_q + 1'b1;
         if (push) begin
            fifo_pc[wr_ptr_q]   <= tag_pc[tag_rd_q];
            fifo_data[wr_ptr_q] <= bus.imem_rsp_data;
            wr_ptr_q            <= wr_ptr_q + 1'b1;
         end
         if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_q + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (accept) tag_pc[tag_wr_q] <= pc_q;
   end
endmodule
